// File: rtl/oam_dma.sv
// Sprite DMA engine: a write to $4014 halts the core and copies a 256-byte page
// to PPU OAMDATA ($2004); otherwise the core's bus passes straight through.
module oam_dma (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_r,
  input  logic        cpu_w,
  output logic        cpu_ce,
  output logic [15:0] A,
  output logic [7:0]  D,
  output logic        R,
  output logic        W,
  input  logic [7:0]  I,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ARM, HALT, ALIGN, RD, WR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  tr_q, tr_d;
  logic        par_q, par_d;
  logic        dma_r_q, dma_r_d;
  logic        dma_w_q, dma_w_d;
  logic [15:0] dma_a;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    tr_d    = tr_q;
    par_d   = par_q;
    dma_r_d = 1'b0;
    dma_w_d = 1'b0;
    if (ce) par_d = ~par_q;
    // Strobes are set on the ce that enters RD/WR so they land one clock later.
    case (state_q)
      IDLE: begin
        if (cpu_w && (cpu_a == 16'h4014)) begin
          page_d  = cpu_d;
          state_d = ARM;
        end
      end
      ARM: begin
        if (ce) begin
          state_d = HALT;
          idx_d   = '0;
        end
      end
      HALT: begin
        if (ce) begin
          if (par_q) begin
            state_d = ALIGN;
          end else begin
            state_d = RD;
            dma_r_d = 1'b1;
          end
        end
      end
      ALIGN: begin
        if (ce) begin
          state_d = RD;
          dma_r_d = 1'b1;
        end
      end
      RD: begin
        if (ce) begin
          tr_d    = I;
          state_d = WR;
          dma_w_d = 1'b1;
        end
      end
      WR: begin
        if (ce) begin
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'hFF) begin
            state_d = IDLE;
          end else begin
            state_d = RD;
            dma_r_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      tr_q    <= '0;
      par_q   <= 1'b0;
      dma_r_q <= 1'b0;
      dma_w_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      tr_q    <= tr_d;
      par_q   <= par_d;
      dma_r_q <= dma_r_d;
      dma_w_q <= dma_w_d;
    end
  end

  assign busy   = (state_q != IDLE) && (state_q != ARM);
  assign dma_a  = (state_q == WR) ? 16'h2004 : {page_q, idx_q};
  assign cpu_ce = ce & ~busy;
  assign A      = busy ? dma_a   : cpu_a;
  assign D      = busy ? tr_q    : cpu_d;
  assign R      = busy ? dma_r_q : cpu_r;
  assign W      = busy ? dma_w_q : cpu_w;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: scoreboard of expected read addresses and
// OAM write data, checked as the engine produces bus strobes.
module tb_oam_dma;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        ce_en = 1'b1;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_r = 1'b0;
  logic        cpu_w = 1'b0;
  logic        cpu_ce;
  logic [15:0] A;
  logic [7:0]  D;
  logic        R, W;
  logic [7:0]  I;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q [$];
  logic [7:0]  wr_q [$];
  logic [15:0] ea, last_rd_a;
  logic [7:0]  ed;
  logic        par_m = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_cnt = 0, wr_cnt = 0, busy_ticks = 0, pre_rd_ticks = 0;

  oam_dma dut (
    .clock(clock), .reset_n(reset_n), .ce(ce),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_r(cpu_r), .cpu_w(cpu_w),
    .cpu_ce(cpu_ce), .A(A), .D(D), .R(R), .W(W), .I(I), .busy(busy)
  );

  assign I = mem[A];

  always #20 clock = ~clock;

  always @(posedge clock) begin
    #1;
    ce = ce_en ? ~ce : 1'b0;
  end

  // Reference parity: toggles on every ce tick since reset
  always @(posedge clock) begin
    if (!reset_n) par_m <= 1'b0;
    else if (ce) par_m <= ~par_m;
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (busy === 1'b1 && ce === 1'b1) begin
        busy_ticks++;
        if (rd_cnt == 0) pre_rd_ticks++;
        n_checks++;
        if (cpu_ce !== 1'b0) begin
          n_fail++;
          $display("FAIL cpu_ce_halted: got %b want 0", cpu_ce);
        end
      end
      if (busy === 1'b1 && R === 1'b1) begin
        rd_cnt++;
        last_rd_a = A;
        n_checks++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_read: A=%h, none expected", A);
        end else begin
          ea = rd_q.pop_front();
          if (A !== ea) begin
            n_fail++;
            $display("FAIL read_addr: got %h want %h", A, ea);
          end
        end
      end
      if (W === 1'b1 && (busy === 1'b1 || A === 16'h2004)) begin
        wr_cnt++;
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL stray_write: W to %h with busy=%b", A, busy);
        end else if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_write: A=%h D=%h, none expected", A, D);
        end else begin
          ed = wr_q.pop_front();
          if (A !== 16'h2004 || D !== ed) begin
            n_fail++;
            $display("FAIL oam_write: got A=%h D=%h want A=2004 D=%h", A, D, ed);
          end
        end
      end
    end
  end

  // Starts a transfer timed so HALT exits with the wanted parity.
  task automatic start_dma(input logic [7:0] pg, input logic want_par, output logic exp_par);
    int unsigned guard;
    guard = 0;
    @(posedge clock); #2;
    while ((~(par_m ^ ce)) !== want_par && guard < 8) begin
      @(posedge clock); #2;
      guard++;
    end
    exp_par = ~(par_m ^ ce);
    rd_q.delete(); wr_q.delete();
    rd_cnt = 0; wr_cnt = 0; busy_ticks = 0; pre_rd_ticks = 0;
    for (int n = 0; n < 256; n++) begin
      rd_q.push_back({pg, 8'(n)});
      wr_q.push_back(mem[{pg, 8'(n)}]);
    end
    cpu_a = 16'h4014; cpu_d = pg; cpu_w = 1'b1;
    @(posedge clock); #2;
    cpu_w = 1'b0; cpu_a = 16'h0000;
  endtask

  task automatic wait_xfer(output bit ok);
    int unsigned k;
    ok = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 20) begin @(posedge clock); #2; k++; end
    if (busy !== 1'b1) ok = 1'b0;
    k = 0;
    while (busy !== 1'b0 && k < 3000) begin @(posedge clock); #2; k++; end
    if (busy !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cpu_a = 16'hABCD; cpu_d = 8'h3C; cpu_r = 1'b1; cpu_w = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    n_checks++;
    if (busy !== 1'b0 || A !== 16'hABCD || D !== 8'h3C || R !== 1'b1 || W !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_passthru: busy=%b A=%h D=%h R=%b W=%b want 0 abcd 3c 1 0", busy, A, D, R, W);
    end
    reset_n = 1'b1;
    @(posedge clock); #2;
    n_checks++;
    if (cpu_ce !== ce || A !== 16'hABCD) begin
      n_fail++;
      $display("FAIL reset_release: cpu_ce=%b want %b A=%h want abcd", cpu_ce, ce, A);
    end
    cpu_r = 1'b0;
  endtask

  task automatic check_done(input string nm, input logic p);
    n_checks++;
    if (busy_ticks !== 513 + int'(p) || rd_cnt !== 256 || wr_cnt !== 256 ||
        pre_rd_ticks !== 1 + int'(p) || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: ticks=%0d want %0d rd=%0d wr=%0d want 256 pre_rd=%0d want %0d", nm,
               busy_ticks, 513 + int'(p), rd_cnt, wr_cnt, pre_rd_ticks, 1 + int'(p));
    end
  endtask

  task automatic test_page02(input logic want_par);
    logic p; bit ok;
    for (int n = 0; n < 256; n++) mem[{8'h02, 8'(n)}] = 8'(n) ^ 8'h5A;
    start_dma(8'h02, want_par, p);
    wait_xfer(ok);
    n_checks++;
    if (!ok || p !== want_par) begin
      n_fail++;
      $display("FAIL xfer_page02_timeout: ok=%b par=%b want 1 %b", ok, p, want_par);
    end
    check_done(want_par ? "xfer_par1" : "xfer_par0", p);
  endtask

  task automatic test_core;
    logic p; bit ok; int unsigned k;
    for (int n = 0; n < 256; n++) mem[{8'h07, 8'(n)}] = 8'($urandom);
    cpu_a = 16'h8000; cpu_r = 1'b1;
    #1;
    n_checks++;
    if (A !== 16'h8000 || R !== 1'b1) begin
      n_fail++;
      $display("FAIL core_fetch: A=%h R=%b want 8000 1", A, R);
    end
    cpu_r = 1'b0;
    start_dma(8'h07, 1'b0, p);
    cpu_a = 16'h8003; cpu_r = 1'b1;
    wait_xfer(ok);
    k = 0;
    while (ce !== 1'b1 && k < 4) begin @(posedge clock); #2; k++; end
    n_checks++;
    if (!ok || cpu_ce !== 1'b1 || A !== 16'h8003 || R !== 1'b1) begin
      n_fail++;
      $display("FAIL core_resume: ok=%b cpu_ce=%b A=%h R=%b want 1 1 8003 1", ok, cpu_ce, A, R);
    end
    check_done("core_xfer", p);
    cpu_r = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic p; int unsigned k; int wr_before;
    start_dma(8'h02, 1'b1, p);
    k = 0;
    while (wr_cnt < 100 && k < 1000) begin @(posedge clock); #2; k++; end
    cpu_a = 16'h1234;
    reset_n = 1'b0;
    @(posedge clock); #2;
    n_checks++;
    if (wr_cnt !== 100 || busy !== 1'b0 || A !== 16'h1234 || W !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: wr=%0d busy=%b A=%h W=%b want 100 0 1234 0", wr_cnt, busy, A, W);
    end
    reset_n = 1'b1;
    rd_q.delete(); wr_q.delete();
    wr_before = wr_cnt; busy_ticks = 0;
    repeat (1200) @(posedge clock);
    #2;
    n_checks++;
    if (wr_cnt !== wr_before || busy_ticks !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_resume: wr=%0d want %0d busy_ticks=%0d want 0", wr_cnt, wr_before, busy_ticks);
    end
  endtask

  task automatic test_invalid;
    logic [15:0] addrs [2];
    addrs[0] = 16'h4015; addrs[1] = 16'h2014;
    busy_ticks = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #2;
      cpu_a = addrs[i]; cpu_d = 8'h12; cpu_w = 1'b1;
      #1;
      n_checks++;
      if (W !== 1'b1 || A !== addrs[i] || D !== 8'h12) begin
        n_fail++;
        $display("FAIL write_passthru: W=%b A=%h D=%h want 1 %h 12", W, A, D, addrs[i]);
      end
      @(posedge clock); #2;
      cpu_w = 1'b0; cpu_a = 16'h0000;
    end
    repeat (12) @(posedge clock);
    #2;
    n_checks++;
    if (busy !== 1'b0 || busy_ticks !== 0) begin
      n_fail++;
      $display("FAIL bad_addr_no_dma: busy=%b ticks=%0d want 0 0", busy, busy_ticks);
    end
  endtask

  task automatic test_page_ff;
    logic p; bit ok;
    for (int n = 0; n < 256; n++) mem[{8'hFF, 8'(n)}] = 8'($urandom);
    start_dma(8'hFF, 1'b0, p);
    wait_xfer(ok);
    n_checks++;
    if (!ok || last_rd_a !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL page_ff_wrap: ok=%b last_read=%h want 1 ffff", ok, last_rd_a);
    end
    check_done("page_ff", p);
  endtask

  task automatic test_freeze;
    logic p; bit ok; int unsigned k; logic [15:0] a0;
    start_dma(8'h02, 1'b1, p);
    k = 0;
    while (rd_cnt < 50 && k < 1000) begin @(posedge clock); #2; k++; end
    ce_en = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    a0 = A;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #2;
      n_checks++;
      if (A !== a0 || R !== 1'b0 || W !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze: A=%h R=%b W=%b busy=%b want %h 0 0 1", A, R, W, busy, a0);
      end
    end
    ce_en = 1'b1;
    wait_xfer(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL freeze_timeout: ok=%b want 1", ok);
    end
    check_done("freeze_resume", p);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_page02(1'b0);
    test_page02(1'b1);
    test_core();
    test_reset_mid();
    test_invalid();
    test_page_ff();
    test_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
